// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the processor's single 32-bit memory port between instruction fetch
// and the load/store path. Each requester holds req (plus its address/data)
// until it sees a combinational gnt. The granted request is registered onto
// mem_*. The transaction then runs until mem_ready, and a one-cycle rvalid
// pulse goes back to the requester that owned the transaction.
// Data requests win arbitration. A saturating streak counter forces a fetch
// grant after MAX_D_STREAK consecutive data grants made while fetch waited.
//
// Ports:
//   clk, reset           clock; asynchronous active-low reset
//   i_req/i_addr/i_gnt   fetch request, word address, accept
//   i_rvalid/i_rdata     fetch response pulse and data (data holds)
//   d_req/d_we/d_addr/d_wdata/d_gnt
//                        load/store request (d_we==0 is a load), accept
//   d_rvalid/d_rdata     load data / store-complete pulse, load data (holds)
//   mem_req/mem_we/mem_addr/mem_wdata
//                        registered memory request, stable per transaction
//   mem_rdata/mem_ready  memory read data and completion strobe

module mem_port_arbiter #(
    parameter int unsigned MAX_D_STREAK = 4   // 1..15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic [3:0]  d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_req,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

    state_t     state, state_next;
    logic [3:0] streak;
    logic       accept;
    logic       grant_i, grant_d;

    // Arbitration and next state. A new request can only be taken when the
    // port is free or the current transaction finishes this cycle. That
    // overlap is what gives back-to-back transactions with no bubble.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_next = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        accept     = (state == IDLE) || mem_ready;

        // NOTE: the reset input also gates the grants. While reset is held,
        // the state reads IDLE, and without this gate the arbiter would
        // still hand out a grant that nothing would ever serve.
        if (reset && accept) begin
            if (d_req && (!i_req || (streak < STREAK_MAX))) begin
                grant_d = 1'b1;
            end else if (i_req) begin
                grant_i = 1'b1;
            end
        end

        if (grant_d) begin
            state_next = BUSY_D;
        end else if (grant_i) begin
            state_next = BUSY_I;
        end else if ((state != IDLE) && mem_ready) begin
            state_next = IDLE;
        end
    end

    assign i_gnt = grant_i;
    assign d_gnt = grant_d;

    // mem_req comes straight from the state register. It is therefore
    // registered, and it drops as soon as the asynchronous reset hits.
    assign mem_req = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state is always updated with non-blocking
            // assignments, so every flop samples pre-edge values.
            state <= state_next;
        end
    end

    // Request registers, streak counter and response registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_we    <= 4'd0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            streak    <= 4'd0;
            i_rvalid  <= 1'b0;
            d_rvalid  <= 1'b0;
            i_rdata   <= 32'd0;
            d_rdata   <= 32'd0;
        end else begin
            // The responses use the pre-edge state and mem_we. These still
            // describe the finishing transaction, even when a new one is
            // granted in the same cycle.
            i_rvalid <= (state == BUSY_I) && mem_ready;
            d_rvalid <= (state == BUSY_D) && mem_ready;
            if ((state == BUSY_I) && mem_ready) begin
                i_rdata <= mem_rdata;
            end
            // A store completion pulses d_rvalid but leaves d_rdata alone.
            if ((state == BUSY_D) && mem_ready && (mem_we == 4'd0)) begin
                d_rdata <= mem_rdata;
            end

            if (grant_d) begin
                mem_we    <= d_we;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
                // The streak only grows while fetch is actually waiting.
                if (i_req) begin
                    streak <= (streak < STREAK_MAX) ? streak + 4'd1 : STREAK_MAX;
                end else begin
                    streak <= 4'd0;
                end
            end else if (grant_i) begin
                mem_we   <= 4'd0;
                mem_addr <= i_addr;
                streak   <= 4'd0;
            end else if ((state != IDLE) && mem_ready) begin
                // The port goes idle. Clear the enables so no stale write
                // strobe remains, and keep the address and data as they are.
                mem_we <= 4'd0;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter.
// Directed part: a cycle table covering single fetch and simultaneous
// requests, followed by hand-written store, starvation, mid-transaction reset
// and ready-in-idle sequences. Random part: requesters and a variable-latency
// memory driven with $urandom, checked every cycle against a transaction-level
// reference model.

module tb_mem_port_arbiter;

    localparam int MAX = 4;

    logic        clk;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req;
    logic [3:0]  d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int errors = 0;
    int checks = 0;

    mem_port_arbiter #(.MAX_D_STREAK(MAX)) dut (
        .clk       (clk),
        .reset     (reset),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_gnt     (i_gnt),
        .i_rvalid  (i_rvalid),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at time %0t, required done", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                         input logic [3:0] dw, input logic [31:0] da, input logic [31:0] dd,
                         input logic rdy, input logic [31:0] rd);
        i_req = ir; i_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
        mem_ready = rdy; mem_rdata = rd;
    endtask

    // Inputs change just after the rising edge, and checks run on the
    // falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        i_req;
        logic [31:0] i_addr;
        logic        d_req;
        logic [3:0]  d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        mem_ready;
        logic [31:0] mem_rdata;
        logic        e_i_gnt;
        logic        e_d_gnt;
        logic        e_mem_req;
        logic [31:0] e_mem_addr;
        logic [3:0]  e_mem_we;
        logic        e_i_rvalid;
        logic        e_d_rvalid;
        logic [31:0] e_i_rdata;
        logic [31:0] e_d_rdata;
    } vec_t;

    vec_t vecs[9];

    // Reference model state (transaction level).
    int          m_owner;     // 0 none, 1 fetch, 2 data
    logic [31:0] m_addr, m_wdata, m_irdata, m_drdata;
    logic [3:0]  m_we;
    int          m_streak;
    logic        m_irv, m_drv;

    initial begin
        logic [1:0] exp_pat [6];
        logic       eg_i, eg_d, accept;
        int         nxt;

        // Single fetch with two wait cycles, then a simultaneous fetch+load.
        //              ir   iaddr          dr   we    daddr          wdata  rdy  rdata          ig dg mr maddr          mwe   irv drv irdata        drdata
        vecs[0] = '{1'b1, 32'h100, 1'b0, 4'h0, 32'h0,   32'h0, 1'b0, 32'h0,        1'b1,1'b0,1'b0,32'h0,   4'h0,1'b0,1'b0,32'h0,        32'h0};
        vecs[1] = '{1'b0, 32'h0,   1'b0, 4'h0, 32'h0,   32'h0, 1'b0, 32'h0,        1'b0,1'b0,1'b1,32'h100, 4'h0,1'b0,1'b0,32'h0,        32'h0};
        vecs[2] = '{1'b0, 32'h0,   1'b0, 4'h0, 32'h0,   32'h0, 1'b0, 32'h0,        1'b0,1'b0,1'b1,32'h100, 4'h0,1'b0,1'b0,32'h0,        32'h0};
        vecs[3] = '{1'b0, 32'h0,   1'b0, 4'h0, 32'h0,   32'h0, 1'b1, 32'hDEADBEEF, 1'b0,1'b0,1'b1,32'h100, 4'h0,1'b0,1'b0,32'h0,        32'h0};
        vecs[4] = '{1'b0, 32'h0,   1'b0, 4'h0, 32'h0,   32'h0, 1'b0, 32'h0,        1'b0,1'b0,1'b0,32'h100, 4'h0,1'b1,1'b0,32'hDEADBEEF, 32'h0};
        vecs[5] = '{1'b1, 32'h140, 1'b1, 4'h0, 32'h200, 32'h0, 1'b0, 32'h0,        1'b0,1'b1,1'b0,32'h100, 4'h0,1'b0,1'b0,32'hDEADBEEF, 32'h0};
        vecs[6] = '{1'b1, 32'h140, 1'b0, 4'h0, 32'h0,   32'h0, 1'b1, 32'h11112222, 1'b1,1'b0,1'b1,32'h200, 4'h0,1'b0,1'b0,32'hDEADBEEF, 32'h0};
        vecs[7] = '{1'b0, 32'h0,   1'b0, 4'h0, 32'h0,   32'h0, 1'b1, 32'h33334444, 1'b0,1'b0,1'b1,32'h140, 4'h0,1'b0,1'b1,32'hDEADBEEF, 32'h11112222};
        vecs[8] = '{1'b0, 32'h0,   1'b0, 4'h0, 32'h0,   32'h0, 1'b0, 32'h0,        1'b0,1'b0,1'b0,32'h140, 4'h0,1'b1,1'b0,32'h33334444, 32'h11112222};

        // ---------------- reset state ----------------
        reset = 1'b0;
        drive(1'b1, 32'h40, 1'b1, 4'h0, 32'h80, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        check("rst_i_gnt", i_gnt, 0);
        check("rst_d_gnt", d_gnt, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_rvalids", {i_rvalid, d_rvalid}, 0);
        check("rst_i_rdata", i_rdata, 0);
        check("rst_d_rdata", d_rdata, 0);
        next_cycle();
        drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        reset = 1'b1;

        // ---------------- table vectors ----------------
        foreach (vecs[k]) begin
            next_cycle();
            drive(vecs[k].i_req, vecs[k].i_addr, vecs[k].d_req, vecs[k].d_we,
                  vecs[k].d_addr, vecs[k].d_wdata, vecs[k].mem_ready, vecs[k].mem_rdata);
            @(negedge clk);
            check($sformatf("vec%0d_i_gnt", k), i_gnt, vecs[k].e_i_gnt);
            check($sformatf("vec%0d_d_gnt", k), d_gnt, vecs[k].e_d_gnt);
            check($sformatf("vec%0d_mem_req", k), mem_req, vecs[k].e_mem_req);
            check($sformatf("vec%0d_mem_addr", k), mem_addr, vecs[k].e_mem_addr);
            check($sformatf("vec%0d_mem_we", k), mem_we, vecs[k].e_mem_we);
            check($sformatf("vec%0d_i_rvalid", k), i_rvalid, vecs[k].e_i_rvalid);
            check($sformatf("vec%0d_d_rvalid", k), d_rvalid, vecs[k].e_d_rvalid);
            check($sformatf("vec%0d_i_rdata", k), i_rdata, vecs[k].e_i_rdata);
            check($sformatf("vec%0d_d_rdata", k), d_rdata, vecs[k].e_d_rdata);
        end

        // ---------------- store ----------------
        next_cycle();
        drive(1'b0, 32'h0, 1'b1, 4'b0011, 32'h300, 32'h0000ABCD, 1'b0, 32'h0);
        @(negedge clk);
        check("st_d_gnt", d_gnt, 1);
        next_cycle();
        drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'hFFFFFFFF);
        @(negedge clk);
        check("st_mem_req", mem_req, 1);
        check("st_mem_we", mem_we, 4'b0011);
        check("st_mem_wdata", mem_wdata, 32'h0000ABCD);
        check("st_mem_addr", mem_addr, 32'h300);
        next_cycle();
        mem_ready = 1'b1; mem_rdata = 32'h55555555;
        @(negedge clk);
        check("st_mem_we_hold", mem_we, 4'b0011);
        check("st_mem_wdata_hold", mem_wdata, 32'h0000ABCD);
        next_cycle();
        mem_ready = 1'b0;
        @(negedge clk);
        check("st_d_rvalid", d_rvalid, 1);
        check("st_d_rdata_unchanged", d_rdata, 32'h11112222);
        check("st_mem_req_off", mem_req, 0);
        check("st_mem_we_cleared", mem_we, 0);
        next_cycle();
        @(negedge clk);
        check("st_d_rvalid_pulse", d_rvalid, 0);

        // ---------------- starvation bound ----------------
        exp_pat = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
        for (int k = 0; k < 6; k++) begin
            next_cycle();
            drive(1'b1, 32'h500, 1'b1, 4'h0, 32'h600 + 32'(k * 4), 32'h0, (k > 0), 32'h0BAD0000 + 32'(k));
            @(negedge clk);
            check($sformatf("starve_gnt%0d", k), {i_gnt, d_gnt}, exp_pat[k]);
        end
        check("starve_fetch_addr", mem_addr, 32'h500);
        next_cycle();
        drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h0);
        @(negedge clk);
        check("starve_fetch_rvalid", i_rvalid, 1);
        check("starve_fetch_rdata", i_rdata, 32'h0BAD0005);
        next_cycle();
        mem_ready = 1'b0;
        @(negedge clk);
        check("starve_idle", mem_req, 0);

        // ---------------- reset mid-transaction ----------------
        next_cycle();
        drive(1'b0, 32'h0, 1'b1, 4'h0, 32'h700, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        check("rm_d_gnt", d_gnt, 1);
        next_cycle();
        d_req = 1'b0;
        @(negedge clk);
        check("rm_busy", mem_req, 1);
        #2;
        reset = 1'b0;
        i_req = 1'b1; d_req = 1'b1;
        #1;
        check("rm_mem_req_drop", mem_req, 0);
        check("rm_mem_addr", mem_addr, 0);
        check("rm_gnts_forced", {i_gnt, d_gnt}, 0);
        mem_ready = 1'b1;
        next_cycle();
        reset = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        check("rm_no_rvalid", {i_rvalid, d_rvalid}, 0);
        next_cycle();
        i_req = 1'b1; i_addr = 32'h800;
        @(negedge clk);
        check("rm_after_i_gnt", i_gnt, 1);
        check("rm_after_no_d_rvalid", d_rvalid, 0);
        next_cycle();
        drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h12345678);
        @(negedge clk);
        check("rm_after_mem_addr", mem_addr, 32'h800);
        next_cycle();
        mem_ready = 1'b0;
        @(negedge clk);
        check("rm_after_i_rvalid", i_rvalid, 1);
        check("rm_after_i_rdata", i_rdata, 32'h12345678);

        // ---------------- ready in IDLE ----------------
        next_cycle();
        mem_ready = 1'b1; mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        check("ri_gnts", {i_gnt, d_gnt}, 0);
        next_cycle();
        mem_ready = 1'b0;
        @(negedge clk);
        check("ri_no_rvalid", {i_rvalid, d_rvalid}, 0);
        check("ri_mem_req", mem_req, 0);
        check("ri_i_rdata", i_rdata, 32'h12345678);
        check("ri_d_rdata", d_rdata, 32'h0);
        next_cycle();
        d_req = 1'b1; d_addr = 32'h900;
        @(negedge clk);
        check("ri_still_idle_gnt", d_gnt, 1);
        next_cycle();
        d_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h0;
        next_cycle();
        mem_ready = 1'b0;

        // ---------------- randomized against the model ----------------
        next_cycle();
        reset = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        #2;
        reset = 1'b1;
        m_owner = 0; m_addr = 0; m_wdata = 0; m_we = 0; m_streak = 0;
        m_irv = 0; m_drv = 0; m_irdata = 0; m_drdata = 0;
        eg_i = 1'b0; eg_d = 1'b0;

        for (int cyc = 0; cyc < 2500; cyc++) begin
            next_cycle();
            // Requesters keep a pending request until it is granted, and
            // now and then withdraw it, which is legal.
            if (i_req && !eg_i && ($urandom_range(0, 15) != 0)) begin
                i_req = 1'b1;
            end else begin
                i_req  = ($urandom_range(0, 1) == 1);
                i_addr = $urandom;
            end
            if (d_req && !eg_d && ($urandom_range(0, 15) != 0)) begin
                d_req = 1'b1;
            end else begin
                d_req   = ($urandom_range(0, 1) == 1);
                d_we    = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
                d_addr  = $urandom;
                d_wdata = $urandom;
            end
            mem_ready = ($urandom_range(0, 4) < 2);
            mem_rdata = $urandom;
            @(negedge clk);

            // Expected arbitration outcome from the rules.
            accept = (m_owner == 0) || mem_ready;
            eg_d = accept && d_req && (!i_req || (m_streak < MAX));
            eg_i = accept && i_req && !eg_d;

            check("rnd_i_gnt", i_gnt, eg_i);
            check("rnd_d_gnt", d_gnt, eg_d);
            check("rnd_mem_req", mem_req, (m_owner != 0));
            check("rnd_mem_addr", mem_addr, m_addr);
            check("rnd_mem_we", mem_we, m_we);
            if (m_owner == 2) check("rnd_mem_wdata", mem_wdata, m_wdata);
            check("rnd_i_rvalid", i_rvalid, m_irv);
            check("rnd_d_rvalid", d_rvalid, m_drv);
            check("rnd_i_rdata", i_rdata, m_irdata);
            check("rnd_d_rdata", d_rdata, m_drdata);

            // Advance the model by one clock.
            m_irv = (m_owner == 1) && mem_ready;
            m_drv = (m_owner == 2) && mem_ready;
            if (m_irv) m_irdata = mem_rdata;
            if (m_drv && (m_we == 4'h0)) m_drdata = mem_rdata;
            nxt = m_owner;
            if (eg_d) begin
                nxt = 2; m_we = d_we; m_addr = d_addr; m_wdata = d_wdata;
                m_streak = i_req ? ((m_streak + 1 > MAX) ? MAX : m_streak + 1) : 0;
            end else if (eg_i) begin
                nxt = 1; m_we = 4'h0; m_addr = i_addr; m_streak = 0;
            end else if ((m_owner != 0) && mem_ready) begin
                nxt = 0; m_we = 4'h0;
            end
            m_owner = nxt;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the processor's single 32-bit memory port between the instruction fetch stage and the execute stage's load/store path. It sits between the pipeline and the memory, and accepts one request per transaction with a req/gnt handshake. It forwards the request to memory with a variable-latency ready handshake, then returns a one-cycle response pulse to the owning requester. Data accesses have priority; a streak counter bounds how long fetch can be starved.

## Interface
- MAX_D_STREAK, 4: maximum consecutive data grants while fetch is waiting; range 1..15.
- clk  in  1  processor clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch read request; held with i_addr until i_gnt.
- i_addr  in  32  fetch word address.
- i_gnt  out  1  fetch request accepted (combinational, this cycle).
- i_rvalid  out  1  one-cycle pulse: i_rdata valid.
- i_rdata  out  32  fetched word; holds until the next i_rvalid.
- d_req  in  1  load/store request; held with d_we, d_addr, d_wdata until d_gnt.
- d_we  in  4  byte write enables; 0 means read.
- d_addr  in  32  data address.
- d_wdata  in  32  store data.
- d_gnt  out  1  data request accepted (combinational).
- d_rvalid  out  1  one-cycle pulse: load data valid or store complete.
- d_rdata  out  32  load data; unchanged on store completion.
- mem_req  out  1  memory transaction active (registered).
- mem_we  out  4  registered byte enables.
- mem_addr  out  32  registered address.
- mem_wdata  out  32  registered write data.
- mem_rdata  in  32  memory read data, valid with mem_ready.
- mem_ready  in  1  memory completes the current transaction this cycle.

## Operation
- States:
  - IDLE: no transaction active.
  - BUSY_I: fetch transaction active.
  - BUSY_D: data transaction active.
- Accept window: the cycle is IDLE, or BUSY_x with mem_ready=1. Outside the accept window both gnt outputs are 0.
- Arbitration inside the accept window:
  - Only one request pending: grant it.
  - Both pending and streak<MAX_D_STREAK: grant data.
  - Both pending and streak==MAX_D_STREAK: grant fetch.
  - At most one gnt is high in any cycle.
- On a grant:
  - Register the granted address, we (0 for fetch) and wdata into mem_*.
  - Set mem_req=1 and go to BUSY_I or BUSY_D.
- Completion without a grant (mem_ready in BUSY, no request pending): go to IDLE, mem_req=0 and mem_we=0. mem_addr and mem_wdata hold.
- On mem_ready in BUSY_I: capture mem_rdata into i_rdata and pulse i_rvalid on the next cycle.
- On mem_ready in BUSY_D:
  - Pulse d_rvalid on the next cycle.
  - Capture mem_rdata into d_rdata only if mem_we==0.
- Streak counter (width 4):
  - Data grant while i_req=1: increment, saturating at MAX_D_STREAK.
  - Data grant while i_req=0: clear.
  - Any fetch grant: clear.
- mem_ready seen in IDLE is ignored.
- mem_* outputs are stable for the whole transaction.

## Timing
- Reset (reset=0), applied asynchronously:
  - state=IDLE, streak=0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - i_rvalid=0, d_rvalid=0, i_rdata=0, d_rdata=0.
  - i_gnt and d_gnt forced to 0.
- Reset mid-transaction abandons the transaction: no rvalid is produced, and mem_req drops immediately.
- Grant at edge N means mem_req=1 from N+1 onward.
- With mem_ready sampled at edge M, rvalid is high during M..M+1, and a new transaction (if granted in that same cycle) has mem_req=1 continuously. Back-to-back transactions have no bubble.
- Minimum latency (request → rvalid):
  - From IDLE with zero-wait memory (mem_ready on the first BUSY cycle): 2 cycles.
  - Each memory wait cycle adds 1.
- One transaction outstanding at a time; no queuing beyond the held requester inputs.
- A request deasserted before its gnt is legal. It is simply not served, and the streak is unaffected.

## Test plan
- Single fetch:
  - Stimulus: IDLE, i_req with i_addr=0x100; memory waits 2 cycles, returns 0xDEADBEEF.
  - Required: i_gnt in cycle 0; mem_req cycles 1–3 with mem_addr=0x100 and mem_we=0; i_rvalid in cycle 4 with i_rdata=0xDEADBEEF; back to IDLE.
- Simultaneous requests:
  - Stimulus: i_req and d_req (load from 0x200) in the same IDLE cycle; zero-wait memory.
  - Required: d_gnt first; i_gnt in the cycle the data mem_ready arrives; mem_addr goes 0x200 then i_addr with no mem_req gap.
- Starvation bound:
  - Stimulus: MAX_D_STREAK=4; i_req and d_req held high continuously.
  - Required: exactly 4 data grants, then 1 fetch grant, then data resumes.
- Store:
  - Stimulus: d_we=4'b0011, d_wdata=0x0000ABCD, d_addr=0x300.
  - Required: mem_we=0011 and mem_wdata=0x0000ABCD for the transaction; d_rvalid pulses; d_rdata unchanged from its previous value.
- Reset mid-transaction:
  - Stimulus: reset=0 asserted while in BUSY_D awaiting mem_ready.
  - Required: mem_req=0 immediately; no d_rvalid; after release, a new i_req is granted normally.
- Ready in IDLE:
  - Stimulus: mem_ready pulsed in IDLE with no requests.
  - Required: no rvalid, state stays IDLE.
